// File: rtl/prim_assembler_if.sv
// Bundles the FIFO-read, primitive-output and mode signals of prim_assembler.
// The assembler drives the master modport; the surrounding FIFOs and consumer use slave.
interface prim_assembler_if #(
    parameter int DATA_W = 96,
    parameter int VERTS  = 3
);
    logic                    mode;
    logic                    vertex_empty;
    logic                    color_empty;
    logic [DATA_W-1:0]       vertex_in;
    logic [DATA_W-1:0]       color_in;
    logic                    vertex_rd_en;
    logic                    color_rd_en;
    logic                    prim_ready;
    logic                    prim_valid;
    logic [VERTS*DATA_W-1:0] vertex_out;
    logic [VERTS*DATA_W-1:0] color_out;
    logic                    flush;

    modport master (
        input  mode, vertex_empty, color_empty, vertex_in, color_in, prim_ready,
        output vertex_rd_en, color_rd_en, prim_valid, vertex_out, color_out, flush
    );

    modport slave (
        output mode, vertex_empty, color_empty, vertex_in, color_in, prim_ready,
        input  vertex_rd_en, color_rd_en, prim_valid, vertex_out, color_out, flush
    );
endinterface

// File: rtl/prim_assembler.sv
// Gathers VERTS vertex/colour pairs from two synchronous FIFOs into primitives,
// with list/strip modes, strip winding correction and in-band flush handling.
module prim_assembler #(
    parameter int                DATA_W     = 96,
    parameter int                VERTS      = 3,
    parameter logic [DATA_W-1:0] FLUSH_WORD = {DATA_W{1'b1}}
) (
    input logic               clk,
    input logic               rst_n,
    prim_assembler_if.master  bus
);
    localparam int CNT_W = $clog2(VERTS + 1);
    localparam int IDX_W = $clog2(VERTS);
    localparam int PW    = VERTS * DATA_W;

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_CAP} rd_state_e;

    rd_state_e         state_q, state_d;
    logic              rd_en_q, rd_en_d;
    logic [CNT_W-1:0]  count_q;
    logic              parity_q;
    logic              mode_q;
    logic              flush_q;
    logic              prim_valid_q;
    logic [PW-1:0]     vout_q, cout_q;
    logic [PW-1:0]     next_v, next_c;
    logic [DATA_W-1:0] slot_v [VERTS];
    logic [DATA_W-1:0] slot_c [VERTS];

    logic full, capture, is_flush, write, xfer;
    logic [IDX_W-1:0] wr_idx;

    assign full     = (count_q == CNT_W'(VERTS));
    assign capture  = (state_q == S_CAP);
    assign is_flush = capture && (bus.vertex_in == FLUSH_WORD) && (bus.color_in == FLUSH_WORD);
    assign write    = capture && !is_flush;
    assign xfer     = full && (!prim_valid_q || bus.prim_ready);
    assign wr_idx   = count_q[IDX_W-1:0];

    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        rd_en_d = 1'b0;
        case (state_q)
            S_REQ: begin
                if (!bus.vertex_empty && !bus.color_empty && !full) begin
                    rd_en_d = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT:  state_d = S_CAP;
            S_CAP:   state_d = S_REQ;
            default: state_d = S_REQ;
        endcase
    end

    // Odd strip primitives swap their first two vertices on the way out only.
    always_comb begin
        next_v = '0;
        next_c = '0;
        for (int i = 0; i < VERTS; i++) begin
            next_v[i*DATA_W +: DATA_W] = slot_v[i];
            next_c[i*DATA_W +: DATA_W] = slot_c[i];
        end
        if (mode_q && parity_q) begin
            next_v[0 +: DATA_W]      = slot_v[1];
            next_v[DATA_W +: DATA_W] = slot_v[0];
            next_c[0 +: DATA_W]      = slot_c[1];
            next_c[DATA_W +: DATA_W] = slot_c[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_REQ;
            rd_en_q  <= 1'b0;
            count_q  <= '0;
            parity_q <= 1'b0;
            mode_q   <= bus.mode;
            flush_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_en_q <= rd_en_d;
            flush_q <= is_flush;
            if (is_flush) begin
                count_q  <= '0;
                parity_q <= 1'b0;
                mode_q   <= bus.mode;
            end else if (write) begin
                count_q <= count_q + 1'b1;
            end else if (xfer) begin
                if (mode_q) begin
                    count_q  <= CNT_W'(VERTS - 1);
                    parity_q <= ~parity_q;
                end else begin
                    count_q <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prim_valid_q <= 1'b0;
            vout_q       <= '0;
            cout_q       <= '0;
        end else if (xfer) begin
            prim_valid_q <= 1'b1;
            vout_q       <= next_v;
            cout_q       <= next_c;
        end else if (bus.prim_ready) begin
            prim_valid_q <= 1'b0;
        end
    end

    // NOTE: the gather buffer is never read before count says it was written, so it carries no reset.
    always_ff @(posedge clk) begin
        if (write) begin
            slot_v[wr_idx] <= bus.vertex_in;
            slot_c[wr_idx] <= bus.color_in;
        end else if (xfer && mode_q) begin
            for (int i = 0; i < VERTS - 1; i++) begin
                slot_v[i] <= slot_v[i+1];
                slot_c[i] <= slot_c[i+1];
            end
        end
    end

    assign bus.vertex_rd_en = rd_en_q;
    assign bus.color_rd_en  = rd_en_q;
    assign bus.prim_valid   = prim_valid_q;
    assign bus.vertex_out   = vout_q;
    assign bus.color_out    = cout_q;
    assign bus.flush        = flush_q;
endmodule
